// File: rtl/a8_cycle_sequencer.sv
// Samples the asynchronous Atari 8-bit bus in the clk200 domain and frames one record per phi2 high phase.
// Records queue in a 2-entry FIFO behind valid/ready; also drives extsel for an address window and a stall watchdog.
module a8_cycle_sequencer #(
  parameter int          SYNC_STAGES = 2,
  parameter int          MIN_HIGH    = 8,
  parameter int          STALL_LIMIT = 255,
  parameter logic [15:0] WIN_BASE    = 16'hD500,
  parameter int          WIN_SIZE    = 256
) (
  input  logic        clk200,
  input  logic        rst,
  input  logic        a8_clk,
  input  logic        a8_rw_n,
  input  logic        a8_halt_n,
  input  logic        a8_ref_n,
  input  logic [15:0] a8_addr,
  input  logic [7:0]  a8_data,
  output logic        cyc_valid,
  input  logic        cyc_ready,
  output logic [15:0] cyc_addr,
  output logic [7:0]  cyc_data,
  output logic        cyc_rw_n,
  output logic        cyc_dma,
  output logic        cyc_ref,
  output logic        a8_extsel_n,
  output logic        bus_stalled,
  output logic        overflow,
  output logic [7:0]  high_width
);

  localparam int          SW     = $clog2(STALL_LIMIT + 1);
  localparam logic [16:0] WIN_LO = {1'b0, WIN_BASE};
  localparam logic [16:0] WIN_HI = WIN_LO + 17'(WIN_SIZE);
  localparam logic [0:0]  IDLE   = 1'b0;
  localparam logic [0:0]  HIGH   = 1'b1;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   s_cur, s_prev, rise, fall, bus_edge;
  logic [18:0]            ctl_pipe  [SYNC_STAGES];
  logic [7:0]             data_pipe [SYNC_STAGES+1];
  logic [15:0]            al_addr;
  logic                   al_rw_n, al_halt_n, al_ref_n, in_win;
  logic [7:0]             old_data;

  logic [0:0]  state;
  logic [7:0]  width;
  logic [15:0] lat_addr;
  logic        lat_rw_n, lat_halt_n, lat_ref_n;
  logic [SW-1:0] stall_cnt;
  logic        stall_hit, push, pop, accept;
  logic [26:0] rec, tail;
  logic [1:0]  count;

  // Sync chain and bus pipeline are left unreset so a reset taken mid-phase cannot fake a rise.
  // Control fields are only ever consumed at the aligned stage, data at the older one.
  always_ff @(posedge clk200) begin
    clk_sync[0] <= a8_clk;
    for (int i = 1; i < SYNC_STAGES; i++) clk_sync[i] <= clk_sync[i-1];
    s_prev <= s_cur;
    ctl_pipe[0]  <= {a8_addr, a8_rw_n, a8_halt_n, a8_ref_n};
    data_pipe[0] <= a8_data;
    for (int i = 1; i < SYNC_STAGES; i++) ctl_pipe[i] <= ctl_pipe[i-1];
    for (int i = 1; i <= SYNC_STAGES; i++) data_pipe[i] <= data_pipe[i-1];
  end

  assign s_cur    = clk_sync[SYNC_STAGES-1];
  assign rise     = s_cur & ~s_prev;
  assign fall     = ~s_cur & s_prev;
  assign bus_edge = rise | fall;
  assign {al_addr, al_rw_n, al_halt_n, al_ref_n} = ctl_pipe[SYNC_STAGES-1];
  assign old_data = data_pipe[SYNC_STAGES];
  assign in_win   = ({1'b0, al_addr} >= WIN_LO) && ({1'b0, al_addr} < WIN_HI);

  assign stall_hit = ~bus_edge && (stall_cnt == SW'(STALL_LIMIT - 1));
  assign push      = (state == HIGH) && fall && (width >= 8'(MIN_HIGH));
  assign rec       = {lat_addr, old_data, lat_rw_n, ~lat_halt_n, ~lat_ref_n};
  assign pop       = cyc_valid & cyc_ready;
  assign accept    = push && ((count != 2'd2) || pop);

  always_ff @(posedge clk200) begin
    if (rst) begin
      stall_cnt   <= '0;
      bus_stalled <= 1'b0;
    end else if (bus_edge) begin
      stall_cnt   <= '0;
      bus_stalled <= 1'b0;
    end else if (stall_cnt != SW'(STALL_LIMIT)) begin
      stall_cnt <= stall_cnt + 1'b1;
      if (stall_hit) bus_stalled <= 1'b1;
    end
  end

  always_ff @(posedge clk200) begin
    if (rst) begin
      state       <= IDLE;
      width       <= '0;
      lat_addr    <= '0;
      lat_rw_n    <= 1'b1;
      lat_halt_n  <= 1'b1;
      lat_ref_n   <= 1'b1;
      a8_extsel_n <= 1'b1;
      high_width  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            lat_addr    <= al_addr;
            lat_rw_n    <= al_rw_n;
            lat_halt_n  <= al_halt_n;
            lat_ref_n   <= al_ref_n;
            width       <= 8'd1;
            a8_extsel_n <= ~in_win;
            state       <= HIGH;
          end
        end
        default: begin
          if (stall_hit || fall) begin
            a8_extsel_n <= 1'b1;
            state       <= IDLE;
            if (push) high_width <= width;
          end else if (width != 8'hFF) begin
            width <= width + 8'd1;
          end
        end
      endcase
    end
  end

  // The output registers are the FIFO head; tail only holds the second queued record.
  always_ff @(posedge clk200) begin
    if (rst) begin
      count     <= '0;
      cyc_valid <= 1'b0;
      {cyc_addr, cyc_data, cyc_rw_n, cyc_dma, cyc_ref} <= {16'h0, 8'h0, 1'b1, 1'b0, 1'b0};
      tail      <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push && !accept) overflow <= 1'b1;
      case (count)
        2'd0: begin
          if (accept) begin
            {cyc_addr, cyc_data, cyc_rw_n, cyc_dma, cyc_ref} <= rec;
            cyc_valid <= 1'b1;
            count     <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && accept) begin
            {cyc_addr, cyc_data, cyc_rw_n, cyc_dma, cyc_ref} <= rec;
          end else if (pop) begin
            cyc_valid <= 1'b0;
            count     <= 2'd0;
          end else if (accept) begin
            tail  <= rec;
            count <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            {cyc_addr, cyc_data, cyc_rw_n, cyc_dma, cyc_ref} <= tail;
            if (accept) tail <= rec;
            else count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule
